fc_w_buf_reader: RTL and testbench
==================================

# fc_w_buf_reader

Read-side sequencer for the FC weight buffer. On a start command it issues `num_rows_i` consecutive row reads (one `FC_SIZE`-byte weight vector per row) from the buffer's read port. Returned vectors go into a small output FIFO and are streamed to the FC PE array over a valid/ready handshake. Together with the buffer's write-side loader, it completes the weight path between load and compute.

## Interface
Parameters:
- `FC_SIZE`, 128, number of byte lanes per weight row; matches the buffer width.
- `ADDR_W`, 7, buffer row address width; depth is 2^ADDR_W.
- `FIFO_DEPTH`, 4, output FIFO entries; minimum 2; 1 row/cycle throughput requires 3 or more.

Ports:
- `clk`  in  1  single clock.
- `rst_all`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  one-cycle command pulse; ignored while `busy_o`=1.
- `base_addr_i`  in  ADDR_W  first row address; sampled with `start_i`.
- `num_rows_i`  in  ADDR_W+1  row count, 0..2^ADDR_W; sampled with `start_i`.
- `busy_o`  out  1  command in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `rden_o`  out  1  buffer read enable; registered.
- `rdptr_o`  out  ADDR_W  buffer read address; registered.
- `weight_i`  in  byte[FC_SIZE]  buffer read data; valid the cycle after `rden_o`.
- `w_valid_o`  out  1  output vector valid.
- `w_ready_i`  in  1  PE array accepts the vector.
- `weight_o`  out  byte[FC_SIZE]  FIFO head vector.
- `w_last_o`  out  1  head vector is the final row of the command.

## Operation
- States:
  - IDLE: waits for a command.
  - ISSUE: reads are being issued.
  - DRAIN: all reads issued; waiting for the FIFO to empty.
  - FIN: one cycle; emits `done_o`.
- IDLE→ISSUE on `start_i` with `num_rows_i`≠0.
  - Latch `rdptr`=`base_addr_i` and `remaining`=`num_rows_i`.
  - `busy_o`=1 from the next cycle.
- IDLE→FIN on `start_i` with `num_rows_i`=0. No reads are issued.
- ISSUE, each cycle: assert `rden_o` iff `fifo_count + inflight < FIFO_DEPTH` and `remaining`>0.
  - `inflight` is 1 when `rden_o` was high in the previous cycle.
  - On each issue, `rdptr` increments modulo 2^ADDR_W (127→0 wraps) and `remaining` decrements.
- ISSUE→DRAIN when the last read issues.
- DRAIN→FIN on the handshake (`w_valid_o & w_ready_i`) of the row tagged last.
- FIN→IDLE unconditionally; `done_o`=1 and `busy_o`=0 in FIN.
- Read returns:
  - The cycle after `rden_o`, `weight_i` is pushed into the FIFO.
  - The entry is tagged last when it is the final issued read.
- The credit rule guarantees that the FIFO never overflows. There is no drop path.
- FIFO output:
  - `w_valid_o` = FIFO not empty.
  - `weight_o` / `w_last_o` = head entry.
  - Pop on handshake.
  - Head data is held stable while `w_valid_o`=1 and `w_ready_i`=0.
- A simultaneous push and pop in the same cycle is legal; `fifo_count` is unchanged.
- `start_i` while busy is ignored entirely; no state is disturbed.

## Timing
- Reset values, all outputs 0: `busy_o`, `done_o`, `rden_o`, `rdptr_o`, `w_valid_o`, `w_last_o`, `weight_o`. Reset also clears the FIFO, the counters and the state (IDLE).
- `rst_all` mid-command: abort immediately.
  - In-flight read data the cycle after reset release is discarded.
  - No `done_o` pulse for the aborted command.
- Command timeline, `start_i` in cycle 0:
  - `rden_o`=1, `rdptr_o`=base in cycle 1.
  - `weight_i` valid in cycle 2.
  - `w_valid_o`=1 in cycle 3.
- With `w_ready_i` held at 1 and `FIFO_DEPTH`≥3: one row per cycle. N rows take the `w_valid_o` cycles 3..N+2.
- `done_o` fires the cycle after the last-row handshake; `busy_o` falls in that same cycle.
- The next `start_i` is accepted in the cycle after FIN.
- `rdptr_o` holds its last value when `rden_o`=0.

## Test plan
- Basic: base=0, rows=4, rows hold 0x10,0x11,0x12,0x13 in lane 0, ready=1.
  - `rden_o` high cycles 1–4 with `rdptr_o`=0,1,2,3.
  - `w_valid_o` cycles 3–6; `w_last_o` only in cycle 6.
  - `done_o` in cycle 7.
- Wrap: base=126, rows=4 → `rdptr_o` sequence 126,127,0,1; data order matches.
- Backpressure: rows=8, `w_ready_i`=0 for cycles 3–10.
  - At most 4 reads are issued before a stall.
  - `weight_o` holds row 0 while stalled.
  - After ready rises, all 8 rows are delivered in order, none lost or duplicated.
- Zero rows: `num_rows_i`=0 → no `rden_o`, `done_o` in cycle 1, `w_valid_o` stays 0.
- Start while busy: second `start_i` in cycle 2 with base=50 → ignored; only the original rows are delivered; a single `done_o`.
- Reset mid-command: assert `rst_all` in cycle 4 of an 8-row read.
  - All outputs go to 0 asynchronously.
  - After release, no `w_valid_o` or `done_o` until a new `start_i`.

Source files
------------

// File: rtl/fc_w_buf_reader.sv
// Read-side sequencer for the FC weight buffer: issues row reads under a FIFO credit
// limit and streams the returned weight vectors to the PE array over valid/ready.
module fc_w_buf_reader #(
  parameter int FC_SIZE    = 128,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_all,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic [ADDR_W:0]         num_rows_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    rden_o,
  output logic [ADDR_W-1:0]       rdptr_o,
  input  logic [FC_SIZE-1:0][7:0] weight_i,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [FC_SIZE-1:0][7:0] weight_o,
  output logic                    w_last_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W+1:0] DEPTH_C = (CNT_W + 2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]          remaining;   // reads still to be issued after the current rden_o
  logic                     rden_last;   // the read on rden_o this cycle is the final one
  logic                     push;        // weight_i carries returned data this cycle
  logic                     push_last;
  logic                     pop;
  logic                     issue;
  logic                     accept;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W+1:0]         credit_used;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [FC_SIZE-1:0][7:0]  mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    last_mem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept    = (state == IDLE) && start_i && (num_rows_i != '0);
  assign w_valid_o = (fifo_count != '0);
  assign pop       = w_valid_o && w_ready_i;

  // Two reads can be outstanding beyond the FIFO (one on rden_o, one returning on
  // weight_i); a pop this cycle frees a slot before either of them lands.
  assign credit_used = {2'b00, fifo_count} + (CNT_W + 2)'(push) + (CNT_W + 2)'(rden_o)
                     - (CNT_W + 2)'(pop);
  assign issue = (state == ISSUE) && (remaining != '0) && (credit_used < DEPTH_C);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = (num_rows_i == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        busy_o = 1'b1;
        if ((remaining == '0) || (issue && (remaining == (ADDR_W + 1)'(1))))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (pop && w_last_o) state_nxt = FIN;
      end
      FIN: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      state     <= IDLE;
      rden_o    <= 1'b0;
      rdptr_o   <= '0;
      remaining <= '0;
      rden_last <= 1'b0;
      push      <= 1'b0;
      push_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      push      <= rden_o;
      push_last <= rden_last;
      if (accept) begin
        rden_o    <= 1'b1;
        rdptr_o   <= base_addr_i;
        remaining <= num_rows_i - 1'b1;
        rden_last <= (num_rows_i == (ADDR_W + 1)'(1));
      end else begin
        rden_o <= issue;
        if (issue) begin
          rdptr_o   <= rdptr_o + 1'b1;
          remaining <= remaining - 1'b1;
          rden_last <= (remaining == (ADDR_W + 1)'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      fifo_count <= '0;
      head       <= '0;
      tail       <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the head is masked until an entry is valid,
  // so stale contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail]      <= weight_i;
      last_mem[tail] <= push_last;
    end
  end

  assign weight_o = w_valid_o ? mem[head] : '0;
  assign w_last_o = w_valid_o && last_mem[head];

endmodule

// File: tb/tb_fc_w_buf_reader.sv
// Self-checking bench for fc_w_buf_reader: a buffer model answers reads, and the delivered
// stream is compared with the row sequence implied by base/count arithmetic.
module tb_fc_w_buf_reader;

  localparam int FC    = 128;
  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int MAXC  = 600;

  typedef logic [FC-1:0][7:0] row_t;

  logic            clk = 1'b0;
  logic            rst_all = 1'b1;
  logic            start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [AW:0]     num_rows_i = '0;
  logic            busy_o, done_o, rden_o, w_valid_o, w_last_o;
  logic [AW-1:0]   rdptr_o;
  row_t            weight_i = '0;
  row_t            weight_o;
  logic            w_ready_i = 1'b1;

  int pass_cnt = 0;
  int total_cnt = 0;

  row_t          buf_mem [128];
  logic          rd_seen = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          v_rden [MAXC];
  logic          v_valid [MAXC];
  logic          v_last [MAXC];
  logic          v_done [MAXC];
  logic          v_busy [MAXC];
  logic          v_ready [MAXC];
  logic [AW-1:0] v_rdptr [MAXC];
  row_t          v_w [MAXC];
  int            ncyc;

  row_t got_w[$];
  logic got_l[$];
  int   got_c[$];

  fc_w_buf_reader #(.FC_SIZE(FC), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_all(rst_all), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_rows_i(num_rows_i), .busy_o(busy_o), .done_o(done_o), .rden_o(rden_o),
    .rdptr_o(rdptr_o), .weight_i(weight_i), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .weight_o(weight_o), .w_last_o(w_last_o)
  );

  always #5 clk = ~clk;

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < FC; i++) r[i] = 8'($urandom);
    return r;
  endfunction

  // Buffer model: data for the address read in one cycle appears in the next; garbage otherwise.
  always @(negedge clk) begin
    rd_seen = rden_o;
    rd_addr = rdptr_o;
  end
  always @(posedge clk) begin
    #1;
    weight_i = rd_seen ? buf_mem[rd_addr] : rand_row();
  end

  function automatic logic [AW-1:0] row_addr(input logic [AW-1:0] base, input int i);
    return AW'((int'(base) + i) % 128);
  endfunction

  // Runs one command with start in cycle 0 and records outputs per cycle at the falling edge.
  // mode 0: ready always 1; mode 1: ready low in cycles 3..10; mode 2: random ready.
  task automatic run_cmd(input logic [AW-1:0] base, input logic [AW:0] rows,
                         input int mode, input int busy_start_cyc);
    int stop_c;
    stop_c = -1;
    ncyc = 0;
    for (int c = 0; c < MAXC; c++) begin
      start_i     = (c == 0) || (c == busy_start_cyc);
      base_addr_i = (c == 0) ? base : 7'd50;
      num_rows_i  = rows;
      case (mode)
        0:       w_ready_i = 1'b1;
        1:       w_ready_i = !(c >= 3 && c <= 10);
        default: w_ready_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      v_rden[c]  = rden_o;   v_rdptr[c] = rdptr_o; v_valid[c] = w_valid_o;
      v_last[c]  = w_last_o; v_done[c]  = done_o;  v_busy[c]  = busy_o;
      v_ready[c] = w_ready_i; v_w[c]    = weight_o;
      ncyc = c + 1;
      if (done_o && stop_c < 0) stop_c = c + 3;
      @(posedge clk); #1;
      if (c == stop_c) break;
    end
    start_i   = 1'b0;
    w_ready_i = 1'b1;
  endtask

  task automatic collect();
    got_w.delete(); got_l.delete(); got_c.delete();
    for (int c = 0; c < ncyc; c++)
      if (v_valid[c] && v_ready[c]) begin
        got_w.push_back(v_w[c]); got_l.push_back(v_last[c]); got_c.push_back(c);
      end
  endtask

  task automatic test_reset();
    rst_all = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy_o, done_o, rden_o, w_valid_o, w_last_o} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {busy_o, done_o, rden_o, w_valid_o, w_last_o});
    else pass_cnt++;
    total_cnt++;
    if (rdptr_o !== '0) $display("FAIL reset_rdptr got=%0d exp=0", rdptr_o); else pass_cnt++;
    total_cnt++;
    if (weight_o !== '0) $display("FAIL reset_weight got=%h exp=0", weight_o[0]); else pass_cnt++;
    rst_all = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic exp_rden, exp_valid;
    int   exp_ptr;
    for (int i = 0; i < 128; i++) buf_mem[i] = rand_row();
    for (int i = 0; i < 4; i++) buf_mem[i][0] = 8'(8'h10 + i);
    run_cmd(7'd0, 8'd4, 0, -1);
    for (int c = 0; c < 10; c++) begin
      exp_rden  = (c >= 1 && c <= 4);
      exp_valid = (c >= 3 && c <= 6);
      exp_ptr   = (c == 0) ? 0 : (c <= 4) ? c - 1 : 3;
      total_cnt++;
      if (v_rden[c] !== exp_rden) $display("FAIL basic_rden c=%0d got=%b exp=%b", c, v_rden[c], exp_rden);
      else pass_cnt++;
      total_cnt++;
      if (v_rdptr[c] !== AW'(exp_ptr)) $display("FAIL basic_rdptr c=%0d got=%0d exp=%0d", c, v_rdptr[c], exp_ptr);
      else pass_cnt++;
      total_cnt++;
      if (v_valid[c] !== exp_valid) $display("FAIL basic_valid c=%0d got=%b exp=%b", c, v_valid[c], exp_valid);
      else pass_cnt++;
      total_cnt++;
      if (v_last[c] !== (c == 6)) $display("FAIL basic_last c=%0d got=%b exp=%b", c, v_last[c], c == 6);
      else pass_cnt++;
      total_cnt++;
      if (v_done[c] !== (c == 7)) $display("FAIL basic_done c=%0d got=%b exp=%b", c, v_done[c], c == 7);
      else pass_cnt++;
      total_cnt++;
      if (v_busy[c] !== (c >= 1 && c <= 6)) $display("FAIL basic_busy c=%0d got=%b", c, v_busy[c]);
      else pass_cnt++;
      if (exp_valid) begin
        total_cnt++;
        if (v_w[c][0] !== 8'(8'h10 + c - 3))
          $display("FAIL basic_lane0 c=%0d got=%h exp=%h", c, v_w[c][0], 8'(8'h10 + c - 3));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap();
    int k;
    logic [AW-1:0] exp_addr [4] = '{7'd126, 7'd127, 7'd0, 7'd1};
    for (int i = 0; i < 128; i++) buf_mem[i] = rand_row();
    run_cmd(7'd126, 8'd4, 0, -1);
    k = 0;
    for (int c = 0; c < ncyc; c++)
      if (v_rden[c]) begin
        total_cnt++;
        if (k >= 4 || v_rdptr[c] !== exp_addr[k % 4])
          $display("FAIL wrap_rdptr idx=%0d got=%0d exp=%0d", k, v_rdptr[c], exp_addr[k % 4]);
        else pass_cnt++;
        k++;
      end
    total_cnt++;
    if (k != 4) $display("FAIL wrap_read_count got=%0d exp=4", k); else pass_cnt++;
    collect();
    total_cnt++;
    if (got_w.size() != 4) $display("FAIL wrap_row_count got=%0d exp=4", got_w.size()); else pass_cnt++;
    for (int i = 0; i < got_w.size() && i < 4; i++) begin
      total_cnt++;
      if (got_w[i] !== buf_mem[exp_addr[i]] || got_l[i] !== (i == 3))
        $display("FAIL wrap_row idx=%0d got=%h/%b exp=%h/%b", i, got_w[i][0], got_l[i],
                 buf_mem[exp_addr[i]][0], i == 3);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] base;
    int reads_stalled;
    base = AW'($urandom_range(0, 127));
    for (int i = 0; i < 128; i++) buf_mem[i] = rand_row();
    run_cmd(base, 8'd8, 1, -1);
    reads_stalled = 0;
    for (int c = 0; c <= 10 && c < ncyc; c++) if (v_rden[c]) reads_stalled++;
    total_cnt++;
    if (reads_stalled > DEPTH || reads_stalled == 0)
      $display("FAIL bp_reads_before_ready got=%0d exp=1..%0d", reads_stalled, DEPTH);
    else pass_cnt++;
    for (int c = 3; c <= 10; c++) begin
      total_cnt++;
      if (v_valid[c] !== 1'b1 || v_w[c] !== buf_mem[base])
        $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, v_valid[c], v_w[c][0], buf_mem[base][0]);
      else pass_cnt++;
    end
    collect();
    total_cnt++;
    if (got_w.size() != 8) $display("FAIL bp_row_count got=%0d exp=8", got_w.size()); else pass_cnt++;
    for (int i = 0; i < got_w.size() && i < 8; i++) begin
      total_cnt++;
      if (got_w[i] !== buf_mem[row_addr(base, i)] || got_l[i] !== (i == 7))
        $display("FAIL bp_row idx=%0d got=%h/%b exp=%h/%b", i, got_w[i][0], got_l[i],
                 buf_mem[row_addr(base, i)][0], i == 7);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_rows();
    int n_rden, n_valid, n_done;
    run_cmd(AW'($urandom_range(0, 127)), 8'd0, 0, -1);
    n_rden = 0; n_valid = 0; n_done = 0;
    for (int c = 0; c < ncyc; c++) begin
      n_rden += int'(v_rden[c]); n_valid += int'(v_valid[c]); n_done += int'(v_done[c]);
    end
    total_cnt++;
    if (n_rden != 0) $display("FAIL zero_rden got=%0d exp=0", n_rden); else pass_cnt++;
    total_cnt++;
    if (n_valid != 0) $display("FAIL zero_valid got=%0d exp=0", n_valid); else pass_cnt++;
    total_cnt++;
    if (ncyc < 2 || v_done[1] !== 1'b1 || n_done != 1)
      $display("FAIL zero_done got_cnt=%0d exp=1 in cycle 1", n_done);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    logic [AW-1:0] base;
    int n_done;
    base = AW'($urandom_range(60, 120));
    for (int i = 0; i < 128; i++) buf_mem[i] = rand_row();
    run_cmd(base, 8'd6, 0, 2);
    collect();
    n_done = 0;
    for (int c = 0; c < ncyc; c++) n_done += int'(v_done[c]);
    total_cnt++;
    if (n_done != 1) $display("FAIL busy_done_count got=%0d exp=1", n_done); else pass_cnt++;
    total_cnt++;
    if (got_w.size() != 6) $display("FAIL busy_row_count got=%0d exp=6", got_w.size()); else pass_cnt++;
    for (int i = 0; i < got_w.size() && i < 6; i++) begin
      total_cnt++;
      if (got_w[i] !== buf_mem[row_addr(base, i)])
        $display("FAIL busy_row idx=%0d got=%h exp=%h", i, got_w[i][0], buf_mem[row_addr(base, i)][0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int n_bad;
    for (int i = 0; i < 128; i++) buf_mem[i] = rand_row();
    base_addr_i = AW'($urandom_range(0, 127));
    num_rows_i  = 8'd8;
    w_ready_i   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      start_i = (c == 0);
      @(posedge clk); #1;
    end
    rst_all = 1'b1;
    #1;
    total_cnt++;
    if ({busy_o, done_o, rden_o, w_valid_o, w_last_o} !== 5'b0 || rdptr_o !== '0 || weight_o !== '0)
      $display("FAIL midreset_async got=%b rdptr=%0d exp=all zero",
               {busy_o, done_o, rden_o, w_valid_o, w_last_o}, rdptr_o);
    else pass_cnt++;
    #1;
    rst_all = 1'b0;
    n_bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (w_valid_o || done_o || rden_o || busy_o) n_bad++;
    end
    total_cnt++;
    if (n_bad != 0) $display("FAIL midreset_quiet got=%0d active cycles exp=0", n_bad); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    logic [AW:0]   rows;
    int n_done, done_c;
    for (int t = 0; t < 6; t++) begin
      base = AW'($urandom_range(0, 127));
      rows = (t == 0) ? 8'd128 : 8'($urandom_range(1, 24));
      for (int i = 0; i < 128; i++) buf_mem[i] = rand_row();
      run_cmd(base, rows, 2, -1);
      collect();
      n_done = 0; done_c = -1;
      for (int c = 0; c < ncyc; c++) if (v_done[c]) begin n_done++; done_c = c; end
      total_cnt++;
      if (got_w.size() != int'(rows))
        $display("FAIL rand_row_count t=%0d got=%0d exp=%0d", t, got_w.size(), rows);
      else pass_cnt++;
      for (int i = 0; i < got_w.size() && i < int'(rows); i++) begin
        total_cnt++;
        if (got_w[i] !== buf_mem[row_addr(base, i)] || got_l[i] !== (i == int'(rows) - 1))
          $display("FAIL rand_row t=%0d idx=%0d got=%h/%b exp=%h/%b", t, i, got_w[i][0], got_l[i],
                   buf_mem[row_addr(base, i)][0], i == int'(rows) - 1);
        else pass_cnt++;
      end
      total_cnt++;
      if (n_done != 1 || got_c.size() == 0 || done_c != got_c[got_c.size() - 1] + 1)
        $display("FAIL rand_done t=%0d got_cnt=%0d at=%0d exp=1 after last handshake", t, n_done, done_c);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) buf_mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_rows();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
